mem_port_arbiter: RTL

Shares the single unified memory port between instruction fetch (requester IF) and the load/store path driven by the decoded mem_params (requester LS).
- One transaction outstanding at a time.
- Round-robin on contention.
- Bounded-wait timeout converts a hung access into an error response.
- Sits between fetch/LSU and the memory model; its busy status feeds the core stall logic.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } arb_state_t;

    // Requester identity; the value doubles as the bit index into the valid vector.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } requester_t;

    // Width of the WAIT-phase timeout counter (TIMEOUT must fit: 1..255).
    localparam int TO_CNT_W = 8;

    // Round-robin tie-break: the requester that did not win last time.
    function automatic requester_t other_requester(input requester_t id);
        return (id == REQ_IF) ? REQ_LS : REQ_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
module arb_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  requester_t last_grant,
    output logic       grant_valid,
    output requester_t grant_id
);

    // Sole requester wins; on a tie the one not granted last time wins.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_valid = |valid;
        grant_id    = REQ_IF;
        if (valid == 2'b11) begin
            grant_id = other_requester(last_grant);
        end else if (valid[REQ_LS]) begin
            grant_id = REQ_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS),
// one transaction at a time, with a bounded wait that turns a hung access
// into an error response.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_rdata,
    output logic                if_resp_err,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_write,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_rdata,
    output logic                ls_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    arb_state_t          state;
    requester_t          last_grant;
    requester_t          grant;
    logic [TO_CNT_W-1:0] to_cnt;
    mem_req_t            req_q;
    mem_req_t            req_new;

    logic       grant_valid;
    requester_t grant_id;
    logic       accept;
    logic       resp_ok;
    logic       resp_to;
    logic [DATA_W-1:0] resp_rdata;

    arb_rr_pick2 u_pick (
        .valid       ({ls_req_valid, if_req_valid}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Request handshake and the command captured on acceptance; fetches are reads.
    always_comb begin
        accept        = (state == ST_IDLE) && !reset && grant_valid;
        if_req_ready  = accept && (grant_id == REQ_IF);
        ls_req_ready  = accept && (grant_id == REQ_LS);
        req_new       = '0;
        req_new.addr  = if_req_addr;
        if (grant_id == REQ_LS) begin
            req_new.addr  = ls_req_addr;
            req_new.write = ls_req_write;
            req_new.wdata = ls_req_wdata;
            req_new.wstrb = ls_req_wstrb;
        end
    end

    // Response steering: a real response beats a same-cycle timeout, and only
    // the granted requester ever sees a pulse.
    always_comb begin
        resp_ok       = (state == ST_WAIT) && !reset && mem_resp_valid;
        resp_to       = (state == ST_WAIT) && !reset && !mem_resp_valid && (to_cnt == TO_LAST);
        resp_rdata    = (resp_ok && !req_q.write) ? mem_rdata : '0;
        if_resp_valid = (resp_ok || resp_to) && (grant == REQ_IF);
        ls_resp_valid = (resp_ok || resp_to) && (grant == REQ_LS);
        if_resp_err   = resp_to && (grant == REQ_IF);
        ls_resp_err   = resp_to && (grant == REQ_LS);
        if_resp_rdata = if_resp_valid ? resp_rdata : '0;
        ls_resp_rdata = ls_resp_valid ? resp_rdata : '0;
    end

    assign mem_req_valid = (state == ST_ISSUE);
    assign mem_addr      = req_q.addr;
    assign mem_write     = req_q.write;
    assign mem_wdata     = req_q.wdata;
    assign mem_wstrb     = req_q.wstrb;
    assign busy          = (state != ST_IDLE);

    // Transaction FSM: accept, issue, wait with timeout, drain a late response.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the captured command is reset because it drives mem_* outputs directly.
            state      <= ST_IDLE;
            last_grant <= REQ_LS;
            grant      <= REQ_LS;
            to_cnt     <= '0;
            req_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        req_q      <= req_new;
                        grant      <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        to_cnt <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    to_cnt <= to_cnt + TO_CNT_W'(1);
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
